fifo_rd_arbiter: RTL and testbench
==================================

// Module: fifo_rd_arbiter
// PURPOSE
//  Round-robin read-port arbiter for the async FIFO read domain. Shares the single FIFO read
//  port between NUM_REQ consumers: grants one requester at a time for a burst of up to
//  2^BURST_W-1 words, drives fifo_rd_en from fifo_empty, and steers returning read data.
//  Sits between the read-pointer handler/FIFO memory and the consumer blocks, all on rdclk.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  8   FIFO word width
//  BURST_W     4   width of each burst-length field
//  MAX_STALL   16  consecutive empty cycles in a burst before abort; 0 = never abort
// PORTS
//  rdclk        in   1                  read-domain clock
//  rrst_n       in   1                  async active-low reset
//  req          in   NUM_REQ            burst request, one bit per requester
//  req_len      in   NUM_REQ*BURST_W    burst length, requester i at [i*BURST_W +: BURST_W]
//  gnt          out  NUM_REQ            one-hot grant, held for the whole burst
//  busy         out  1                  high when state != IDLE
//  fifo_empty   in   1                  registered empty flag from the read-pointer handler
//  fifo_rd_en   out  1                  FIFO read strobe
//  fifo_rdata   in   DATA_WIDTH         FIFO read data, valid the cycle after fifo_rd_en
//  rd_data      out  DATA_WIDTH         = fifo_rdata (pass-through)
//  rd_valid     out  NUM_REQ            one-hot: rd_data belongs to requester i this cycle
//  burst_done   out  NUM_REQ            1-cycle pulse to granted requester at end of burst
//  burst_abort  out  1                  1-cycle pulse coincident with burst_done on stall timeout
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gnt=0, busy=0, fifo_rd_en=0, rd_valid=0,
//   burst_done=0, burst_abort=0, remaining=0, stall_cnt=0, rr_last=NUM_REQ-1.
//   An in-flight read beat is discarded.
//  FSM states: IDLE, READ, TAIL.
//  IDLE: req sampled only here. If any req bit is set, pick the first set bit searching
//   from rr_last+1 upward, with wrap. Latch idx and remaining = (len==0 ? 1 : len).
//   Register gnt=onehot(idx) and go to READ. Otherwise stay; gnt=0.
//  READ: fifo_rd_en = !fifo_empty (combinational from state and input). Each rd_en
//   decrements remaining. rd_en with remaining==1 -> TAIL.
//   stall_cnt: +1 on each READ cycle with fifo_empty, cleared on rd_en.
//   MAX_STALL!=0 and stall_cnt reaches MAX_STALL-1 while empty -> TAIL with abort flag set.
//  TAIL (1 cycle): fifo_rd_en=0. burst_done[idx]=1 and burst_abort=abort flag. gnt held.
//   rr_last<=idx. Next state IDLE with gnt=0.
//  rd_valid = onehot(idx) gated by rd_en delayed 1 cycle. Data latency is 1 cycle after
//   rd_en; the last beat lands in TAIL.
//  Timing (FIFO never empty, len L, req seen in cycle 0): gnt in cycles 1..L+1,
//   rd_en in cycles 1..L, rd_valid in cycles 2..L+1, burst_done in cycle L+1,
//   IDLE in cycle L+2, next gnt no earlier than cycle L+3.
//  req/req_len changes during a burst are ignored. A requester still holding req after
//   burst_done is re-arbitrated behind other pending requesters.
//  Aborted burst: remaining words are dropped, not re-issued. rd_valid count equals the
//   number of words actually read.
//  Width rules: remaining is BURST_W bits; stall_cnt is $clog2(MAX_STALL+1) bits and saturates.
// TESTING
//  1. req=0001, len0=4, empty=0, rdata A0..A3 -> rd_en cycles 1-4; rd_valid=0001 cycles 2-5
//     with A0..A3; burst_done=0001 cycle 5; gnt=0001 cycles 1-5.
//  2. req=0101 held after reset, len=2 each -> grant order 0,2,0,2. rr_last alternates;
//     no requester is starved.
//  3. len0=0 -> exactly one rd_en and one rd_valid[0]; burst_done after 1 beat.
//  4. len1=6, empty=1 for 3 cycles after beat 2 -> rd_en low 3 cycles, remaining held at 4;
//     all 6 beats delivered; burst_abort=0.
//  5. MAX_STALL=16, len3=8, empty stuck after 2 beats -> TAIL after 16 stall cycles;
//     burst_done[3]=1 and burst_abort=1; exactly 2 rd_valid[3] pulses.
//  6. rrst_n low mid-burst (beat 3 of 8) -> gnt, rd_en, rd_valid, busy drop to 0 the same
//     cycle. After release with req=1111, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the single FIFO read port among NUM_REQ consumers on rdclk.
// Grants one requester per burst, strobes fifo_rd_en while data is available, and tags returning data.
module fifo_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_W    = 4,
    parameter int MAX_STALL  = 16
) (
    input  logic                       rdclk,
    input  logic                       rrst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BURST_W-1:0] req_len,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]      fifo_rdata,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [NUM_REQ-1:0]         rd_valid,
    output logic [NUM_REQ-1:0]         burst_done,
    output logic                       burst_abort
);

    // Handshake: a requester holds req[i] with req_len[i] until it sees gnt[i]; the grant is
    // held for the whole burst, each rd_valid[i] cycle carries one word, burst_done[i] ends it.

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int STALL_W = (MAX_STALL == 0) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'((MAX_STALL == 0) ? 0 : MAX_STALL - 1);
    localparam logic [STALL_W-1:0] STALL_SAT = '1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [BURST_W-1:0] ONE_LEN   = BURST_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt, rr_last, pick_idx, cand;
    logic               pick_vld;
    logic [BURST_W-1:0] remaining, remaining_nxt, pick_len;
    logic [BURST_W-1:0] len_arr [NUM_REQ];
    logic [STALL_W-1:0] stall_cnt, stall_nxt;
    logic               abort_q, abort_nxt;
    logic               rd_en_q;
    logic [NUM_REQ-1:0] idx_onehot;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            len_arr[i] = req_len[i*BURST_W +: BURST_W];
        end
    end

    // Walk offsets from farthest to nearest so the first set bit after rr_last wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(rr_last) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick_len = len_arr[pick_idx];

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        remaining_nxt = remaining;
        stall_nxt     = stall_cnt;
        abort_nxt     = abort_q;
        fifo_rd_en    = 1'b0;
        case (state)
            IDLE: begin
                stall_nxt = '0;
                abort_nxt = 1'b0;
                if (pick_vld) begin
                    idx_nxt       = pick_idx;
                    remaining_nxt = (pick_len == '0) ? ONE_LEN : pick_len;
                    state_nxt     = READ;
                end
            end
            READ: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    stall_nxt     = '0;
                    remaining_nxt = remaining - ONE_LEN;
                    if (remaining == ONE_LEN) begin
                        state_nxt = TAIL;
                    end
                end else begin
                    if (stall_cnt != STALL_SAT) begin
                        stall_nxt = stall_cnt + 1'b1;
                    end
                    // Words not yet read are dropped on a stall timeout.
                    if (MAX_STALL != 0 && stall_cnt == STALL_LIM) begin
                        abort_nxt = 1'b1;
                        state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge rdclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            stall_cnt <= '0;
            abort_q   <= 1'b0;
            rr_last   <= LAST_IDX;
            rd_en_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            remaining <= remaining_nxt;
            stall_cnt <= stall_nxt;
            abort_q   <= abort_nxt;
            rd_en_q   <= fifo_rd_en;
            if (state == TAIL) begin
                rr_last <= idx;
            end
        end
    end

    // Outputs decode from registered state, so an async reset clears them at once.
    assign idx_onehot  = NUM_REQ'(1) << idx;
    assign busy        = (state != IDLE);
    assign gnt         = busy ? idx_onehot : '0;
    assign burst_done  = (state == TAIL) ? idx_onehot : '0;
    assign burst_abort = (state == TAIL) && abort_q;
    assign rd_valid    = rd_en_q ? idx_onehot : '0;
    assign rd_data     = fifo_rdata;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: burst timing, round-robin order, zero length,
// empty stalls, stall abort and mid-burst async reset.
module tb_fifo_rd_arbiter;

    logic        rdclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_len = '0;
    logic [3:0]  gnt, rd_valid, burst_done;
    logic        busy, fifo_rd_en, burst_abort;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rdata = '0;
    logic [7:0]  rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int beat_idx = 0;
    int rd_cnt = 0;
    int n_rden = 0;
    int n_valid [4];

    always #5 rdclk = ~rdclk;

    fifo_rd_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .BURST_W(4), .MAX_STALL(16)
    ) dut (
        .rdclk(rdclk), .rrst_n(rrst_n), .req(req), .req_len(req_len),
        .gnt(gnt), .busy(busy), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .burst_done(burst_done), .burst_abort(burst_abort)
    );

    // FIFO memory model: word n read out is 8'hA0 + n, one cycle after the strobe.
    always @(posedge rdclk) begin
        if (fifo_rd_en) begin
            fifo_rdata <= 8'(32'hA0 + rd_cnt);
            rd_cnt     <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge rdclk);
        #1;
    endtask

    task automatic observe();
        logic [7:0] exp_d;
        #2;
        if (fifo_rd_en) n_rden++;
        for (int i = 0; i < 4; i++) begin
            if (rd_valid[i]) n_valid[i]++;
        end
        if (rd_valid != '0) begin
            exp_d = 8'(32'hA0 + beat_idx);
            check("rd_data", 32'(rd_data), 32'(exp_d));
            check("rd_valid onehot", 32'($countones(rd_valid)), 32'd1);
            beat_idx++;
        end
    endtask

    task automatic clear_counts();
        n_rden = 0;
        for (int i = 0; i < 4; i++) n_valid[i] = 0;
    endtask

    task automatic set_len(input int r, input int len);
        req_len[r*4 +: 4] = 4'(len);
    endtask

    task automatic do_reset();
        rrst_n     = 1'b0;
        req        = '0;
        req_len    = '0;
        fifo_empty = 1'b1;
        repeat (2) @(posedge rdclk);
        #1;
        rrst_n   = 1'b1;
        beat_idx = rd_cnt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] eg;

        // Single burst of 4 words, FIFO never empty.
        do_reset();
        clear_counts();
        req = 4'b0001; set_len(0, 4); fifo_empty = 1'b0;
        observe();
        check("reset gnt", 32'(gnt), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset burst_done", 32'(burst_done), 32'd0);
        check("reset burst_abort", 32'(burst_abort), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 1) req = '0;
            observe();
            check($sformatf("t1 gnt c%0d", c), 32'(gnt), (c <= 5) ? 32'd1 : 32'd0);
            check($sformatf("t1 rd_en c%0d", c), 32'(fifo_rd_en), (c <= 4) ? 32'd1 : 32'd0);
            check($sformatf("t1 rd_valid c%0d", c), 32'(rd_valid), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            check($sformatf("t1 done c%0d", c), 32'(burst_done), (c == 5) ? 32'd1 : 32'd0);
            check($sformatf("t1 busy c%0d", c), 32'(busy), (c <= 5) ? 32'd1 : 32'd0);
        end
        check("t1 beats", 32'(n_valid[0]), 32'd4);

        // Requesters 0 and 2 held: grants alternate 0,2,0,2 every 4 cycles.
        do_reset();
        clear_counts();
        req = 4'b0101; set_len(0, 2); set_len(2, 2); fifo_empty = 1'b0;
        observe();
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            if (c == 16) req = '0;
            observe();
            eg = (((c - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0100;
            if (c <= 16) begin
                check($sformatf("t2 gnt c%0d", c), 32'(gnt), ((c - 1) % 4 <= 2) ? 32'(eg) : 32'd0);
                check($sformatf("t2 done c%0d", c), 32'(burst_done), ((c - 1) % 4 == 2) ? 32'(eg) : 32'd0);
            end else begin
                check("t2 idle after drop", 32'(busy), 32'd0);
            end
        end
        check("t2 beats r0", 32'(n_valid[0]), 32'd4);
        check("t2 beats r2", 32'(n_valid[2]), 32'd4);

        // Zero length means one word.
        next_cycle();
        clear_counts();
        req = 4'b0001; set_len(0, 0);
        observe();
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 1) req = '0;
            observe();
            check($sformatf("t3 gnt c%0d", c), 32'(gnt), (c <= 2) ? 32'd1 : 32'd0);
            check($sformatf("t3 done c%0d", c), 32'(burst_done), (c == 2) ? 32'd1 : 32'd0);
        end
        check("t3 rd_en count", 32'(n_rden), 32'd1);
        check("t3 beats", 32'(n_valid[0]), 32'd1);

        // Length 6 with a 3-cycle empty gap after beat 2.
        next_cycle();
        clear_counts();
        req = 4'b0010; set_len(1, 6); fifo_empty = 1'b0;
        observe();
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            if (c == 1) req = '0;
            fifo_empty = (c >= 3 && c <= 5);
            observe();
            check($sformatf("t4 rd_en c%0d", c), 32'(fifo_rd_en), (c <= 2 || (c >= 6 && c <= 9)) ? 32'd1 : 32'd0);
            check($sformatf("t4 done c%0d", c), 32'(burst_done), (c == 10) ? 32'd2 : 32'd0);
            check($sformatf("t4 abort c%0d", c), 32'(burst_abort), 32'd0);
        end
        check("t4 beats", 32'(n_valid[1]), 32'd6);

        // Empty stuck after 2 beats: abort after 16 stall cycles.
        next_cycle();
        clear_counts();
        req = 4'b1000; set_len(3, 8); fifo_empty = 1'b0;
        observe();
        for (int c = 1; c <= 21; c++) begin
            next_cycle();
            if (c == 1) req = '0;
            fifo_empty = (c >= 3);
            observe();
            check($sformatf("t5 rd_en c%0d", c), 32'(fifo_rd_en), (c <= 2) ? 32'd1 : 32'd0);
            check($sformatf("t5 done c%0d", c), 32'(burst_done), (c == 19) ? 32'd8 : 32'd0);
            check($sformatf("t5 abort c%0d", c), 32'(burst_abort), (c == 19) ? 32'd1 : 32'd0);
            check($sformatf("t5 busy c%0d", c), 32'(busy), (c <= 19) ? 32'd1 : 32'd0);
        end
        check("t5 beats", 32'(n_valid[3]), 32'd2);

        // Async reset during beat 3 of 8, then all four request.
        do_reset();
        clear_counts();
        req = 4'b0001; set_len(0, 8); fifo_empty = 1'b0;
        observe();
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 1) req = '0;
            observe();
        end
        check("t6 rd_en before rst", 32'(fifo_rd_en), 32'd1);
        check("t6 rd_valid before rst", 32'(rd_valid), 32'd1);
        rrst_n = 1'b0;
        #1;
        check("t6 rst gnt", 32'(gnt), 32'd0);
        check("t6 rst rd_en", 32'(fifo_rd_en), 32'd0);
        check("t6 rst rd_valid", 32'(rd_valid), 32'd0);
        check("t6 rst busy", 32'(busy), 32'd0);
        req = 4'b1111;
        for (int r = 0; r < 4; r++) set_len(r, 1);
        next_cycle();
        next_cycle();
        rrst_n   = 1'b1;
        beat_idx = rd_cnt;
        observe();
        check("t6 release rd_valid", 32'(rd_valid), 32'd0);
        check("t6 release gnt", 32'(gnt), 32'd0);
        next_cycle();
        req = '0;
        observe();
        check("t6 first gnt", 32'(gnt), 32'd1);
        check("t6 rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle();
        observe();
        check("t6 last beat", 32'(rd_valid), 32'd1);
        check("t6 done", 32'(burst_done), 32'd1);
        next_cycle();
        observe();
        check("t6 idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
